// File: rtl/rv32i_mem_pkg.sv
// Shared types and RV32I access-size helpers for the byte-serial memory sequencer.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {IDLE, XFER, RESP, DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Number of RAM byte cycles for a size code; 0 flags an illegal code.
  function automatic logic [2:0] f3_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: f3_bytes = 3'd1;
      F3_H, F3_HU: f3_bytes = 3'd2;
      F3_W:        f3_bytes = 3'd4;
      default:     f3_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_load_ext.sv
// RV32I load extension: turns an assembled little-endian word into the
// architecturally visible value for B/H/W/BU/HU.
module rv32i_load_ext
  import rv32i_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    // NOTE: every case arm (and the default) assigns result, so no latch is inferred.
    case (funct3)
      F3_B:    result = {{24{word[7]}}, word[7:0]};
      F3_H:    result = {{16{word[15]}}, word[15:0]};
      F3_BU:   result = {24'h000000, word[7:0]};
      F3_HU:   result = {16'h0000, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_sequencer.sv
// Round-robin sequencer sharing one byte-wide synchronous RAM between the
// fetch and load/store ports; each access is split into 1, 2 or 4 byte cycles.
module rv32i_mem_sequencer
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W = 12
)
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy
);

  state_t      state;
  logic [1:0]  cnt;
  logic [2:0]  n_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic        data_q;
  logic        last_data;
  logic [23:0] wdata_q;
  logic [23:0] rbuf;

  logic              grant_data;
  logic [2:0]        g_f3;
  logic [2:0]        g_n;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0]       g_wdata;
  logic              last_byte;
  logic [31:0]       asm_word;
  logic [31:0]       ext_word;
  logic              unused_addr_hi;

  // On a tie the port that was not served last wins.
  assign grant_data = d_req & (~if_req | ~last_data);
  assign g_f3       = grant_data ? d_funct3 : F3_W;
  assign g_n        = f3_bytes(g_f3);
  assign g_we       = grant_data & d_we;
  assign g_addr     = grant_data ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
  assign g_wdata    = grant_data ? d_wdata : 32'h0;
  assign last_byte  = ({1'b0, cnt} == n_q - 3'd1);

  assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  // In RESP cnt still points at the last byte, which arrives on ram_rdata now.
  always_comb begin
    asm_word = {8'h00, rbuf};
    case (cnt)
      2'd0: asm_word[7:0]   = ram_rdata;
      2'd1: asm_word[15:8]  = ram_rdata;
      2'd2: asm_word[23:16] = ram_rdata;
      2'd3: asm_word[31:24] = ram_rdata;
    endcase
  end

  rv32i_load_ext u_load_ext (
    .word   (asm_word),
    .funct3 (f3_q),
    .result (ext_word)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      n_q       <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      data_q    <= 1'b0;
      last_data <= 1'b1;
      wdata_q   <= '0;
      rbuf      <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | d_req) begin
            data_q  <= grant_data;
            we_q    <= g_we;
            f3_q    <= g_f3;
            n_q     <= g_n;
            wdata_q <= g_wdata[31:8];
            cnt     <= '0;
            busy    <= 1'b1;
            if (g_n == 3'd0) begin
              state  <= DONE;
              d_done <= 1'b1;
              if (!g_we) d_rdata <= '0;
            end else begin
              state     <= XFER;
              ram_en    <= 1'b1;
              ram_we    <= g_we;
              ram_addr  <= g_addr;
              ram_wdata <= g_wdata[7:0];
            end
          end
        end
        XFER: begin
          if (!we_q) begin
            case (cnt)
              2'd1:    rbuf[7:0]   <= ram_rdata;
              2'd2:    rbuf[15:8]  <= ram_rdata;
              2'd3:    rbuf[23:16] <= ram_rdata;
              default: ;
            endcase
          end
          if (last_byte) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            if (we_q) begin
              state  <= DONE;
              d_done <= 1'b1;
            end else begin
              state <= RESP;
            end
          end else begin
            cnt       <= cnt + 2'd1;
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_wdata <= wdata_q[7:0];
            wdata_q   <= {8'h00, wdata_q[23:8]};
          end
        end
        RESP: begin
          state <= DONE;
          if (data_q) begin
            d_rdata <= ext_word;
            d_done  <= 1'b1;
          end else begin
            if_rdata <= ext_word;
            if_done  <= 1'b1;
          end
        end
        DONE: begin
          last_data <= data_q;
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_sequencer.sv
// Self-checking bench for rv32i_mem_sequencer: behavioural byte RAM, a
// reference memory model, directed scenarios and randomized accesses.
module tb_rv32i_mem_sequencer;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic        busy;

  logic [7:0] ram       [0:4095];
  logic [7:0] model_mem [0:4095];

  int checks = 0;
  int failures = 0;

  int         obs_done;
  int         obs_nram;
  int         obs_stray;
  logic [11:0] obs_a  [0:3];
  logic [7:0]  obs_wd [0:3];

  rv32i_mem_sequencer #(.ADDR_W(12)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_funct3  (d_funct3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Single-port synchronous byte RAM: read data appears the cycle after the request.
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] = ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  function automatic logic [11:0] idx(input logic [31:0] a, input int i);
    logic [31:0] s;
    s = a + 32'(i);
    return s[11:0];
  endfunction

  function automatic int model_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < model_bytes(f3); i++)
      v = v + (32'(model_mem[idx(a, i)]) << (8 * i));
    if (f3 == F3_B && v >= 32'd128)   v = v - 32'd256;
    if (f3 == F3_H && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] w);
    for (int i = 0; i < model_bytes(f3); i++)
      model_mem[idx(a, i)] = 8'(w >> (8 * i));
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] b);
    ram[a] = b;
    model_mem[a] = b;
  endtask

  // Issues one access from an idle sequencer and records what the RAM port and
  // done outputs did; cycle 0 is the cycle in which the request is first seen.
  task automatic run_access(input bit is_d, input bit we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
    obs_done = -1;
    obs_nram = 0;
    obs_stray = 0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(negedge clock);
    if (ram_en) obs_nram++;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (ram_en) begin
        if (obs_nram < 4) begin
          obs_a[obs_nram]  = ram_addr;
          obs_wd[obs_nram] = ram_wdata;
        end
        obs_nram++;
      end
      if (is_d ? if_done : d_done) obs_stray++;
      if (is_d ? d_done : if_done) begin
        obs_done = c;
        break;
      end
    end
    @(posedge clock);
    #1;
    if_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({if_done, d_done, ram_en, ram_we, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {if_done, d_done, ram_en, ram_we, busy});
    end
    checks++;
    if ({ram_addr, ram_wdata} !== 20'h0) begin
      failures++;
      $display("FAIL reset_ram_bus: got %h expected 00000", {ram_addr, ram_wdata});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_word_fetch();
    preload(12'h100, 8'h13);
    preload(12'h101, 8'h05);
    preload(12'h102, 8'h10);
    preload(12'h103, 8'h00);
    run_access(1'b0, 1'b0, F3_W, 32'h0000_0100, 32'h0);
    checks++;
    if (obs_done !== 6) begin
      failures++;
      $display("FAIL fetch_done_cycle: got %0d expected 6", obs_done);
    end
    checks++;
    if (obs_nram !== 4) begin
      failures++;
      $display("FAIL fetch_ram_cycles: got %0d expected 4", obs_nram);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_a[i] !== 12'h100 + 12'(i)) begin
        failures++;
        $display("FAIL fetch_addr[%0d]: got %h expected %h", i, obs_a[i], 12'h100 + 12'(i));
      end
    end
    checks++;
    if (if_rdata !== 32'h0010_0513) begin
      failures++;
      $display("FAIL fetch_rdata: got %h expected 00100513", if_rdata);
    end
  endtask

  task automatic test_byte_loads();
    preload(12'h020, 8'h80);
    run_access(1'b1, 1'b0, F3_B, 32'h0000_0020, $urandom);
    checks++;
    if (obs_done !== 3) begin
      failures++;
      $display("FAIL lb_done_cycle: got %0d expected 3", obs_done);
    end
    checks++;
    if (obs_nram !== 1 || obs_a[0] !== 12'h020) begin
      failures++;
      $display("FAIL lb_ram: got n=%0d a=%h expected n=1 a=020", obs_nram, obs_a[0]);
    end
    checks++;
    if (d_rdata !== 32'hFFFF_FF80) begin
      failures++;
      $display("FAIL lb_rdata: got %h expected ffffff80", d_rdata);
    end
    run_access(1'b1, 1'b0, F3_BU, 32'h0000_0020, $urandom);
    checks++;
    if (obs_done !== 3) begin
      failures++;
      $display("FAIL lbu_done_cycle: got %0d expected 3", obs_done);
    end
    checks++;
    if (d_rdata !== 32'h0000_0080) begin
      failures++;
      $display("FAIL lbu_rdata: got %h expected 00000080", d_rdata);
    end
  endtask

  task automatic test_store_wrap();
    run_access(1'b1, 1'b1, F3_H, 32'h0000_0FFF, 32'hAABB_CCDD);
    model_store(32'h0000_0FFF, F3_H, 32'hAABB_CCDD);
    checks++;
    if (obs_done !== 3) begin
      failures++;
      $display("FAIL sh_done_cycle: got %0d expected 3", obs_done);
    end
    checks++;
    if (obs_nram !== 2) begin
      failures++;
      $display("FAIL sh_ram_cycles: got %0d expected 2", obs_nram);
    end
    checks++;
    if (obs_a[0] !== 12'hFFF || obs_a[1] !== 12'h000) begin
      failures++;
      $display("FAIL sh_wrap_addr: got %h,%h expected fff,000", obs_a[0], obs_a[1]);
    end
    checks++;
    if (ram[12'hFFF] !== 8'hDD || ram[12'h000] !== 8'hCC) begin
      failures++;
      $display("FAIL sh_ram_bytes: got %h,%h expected dd,cc", ram[12'hFFF], ram[12'h000]);
    end
  endtask

  task automatic test_illegal();
    run_access(1'b1, 1'b0, 3'b011, 32'h0000_0020, 32'h0);
    checks++;
    if (obs_done !== 1) begin
      failures++;
      $display("FAIL illegal_ld_done_cycle: got %0d expected 1", obs_done);
    end
    checks++;
    if (obs_nram !== 0) begin
      failures++;
      $display("FAIL illegal_ld_ram_cycles: got %0d expected 0", obs_nram);
    end
    checks++;
    if (d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL illegal_ld_rdata: got %h expected 00000000", d_rdata);
    end
    run_access(1'b1, 1'b1, 3'b110, 32'h0000_0030, $urandom);
    checks++;
    if (obs_done !== 1 || obs_nram !== 0) begin
      failures++;
      $display("FAIL illegal_st: got done=%0d n=%0d expected done=1 n=0", obs_done, obs_nram);
    end
    checks++;
    if (ram[12'h030] !== model_mem[12'h030]) begin
      failures++;
      $display("FAIL illegal_st_mem: got %h expected %h", ram[12'h030], model_mem[12'h030]);
    end
  endtask

  task automatic test_arbitration();
    int          order [0:3];
    int          when  [0:3];
    int          nd;
    int          c;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    exp_if = model_read(32'h100, F3_W);
    exp_d  = model_read(32'h200, F3_W);
    for (int k = 0; k < 4; k++) begin
      order[k] = -1;
      when[k]  = -1;
    end
    nd = 0;
    c  = 0;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = F3_W; d_addr = 32'h0000_0200;
    while (nd < 4 && c < 60) begin
      @(posedge clock);
      c++;
      @(negedge clock);
      if (if_done || d_done) begin
        checks++;
        if (if_done && d_done) begin
          failures++;
          $display("FAIL arb_dual_done: both done pulses at cycle %0d", c);
        end
        checks++;
        if (if_done && if_rdata !== exp_if) begin
          failures++;
          $display("FAIL arb_if_rdata: got %h expected %h", if_rdata, exp_if);
        end else if (!if_done && d_rdata !== exp_d) begin
          failures++;
          $display("FAIL arb_d_rdata: got %h expected %h", d_rdata, exp_d);
        end
        order[nd] = d_done ? 1 : 0;
        when[nd]  = c;
        nd++;
      end
    end
    @(posedge clock);
    #1;
    if_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (nd !== 4) begin
      failures++;
      $display("FAIL arb_done_count: got %0d expected 4", nd);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (order[k] !== (k % 2) || when[k] !== 6 + 7 * k) begin
        failures++;
        $display("FAIL arb_grant[%0d]: got port=%0d cycle=%0d expected port=%0d cycle=%0d",
                 k, order[k], when[k], k % 2, 6 + 7 * k);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] a;
    logic [31:0] w;
    a = 32'h0000_0340;
    w = $urandom;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = F3_W; d_addr = a; d_wdata = w;
    repeat (3) @(posedge clock);
    // Two byte writes have committed; byte 2 is on the RAM port.
    #2;
    reset_n = 1'b0;
    d_req = 1'b0;
    #1;
    checks++;
    if (ram_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_abort: got ram_en=%b busy=%b expected 0 0", ram_en, busy);
    end
    checks++;
    if ({if_rdata, d_rdata, if_done, d_done} !== 66'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h expected 0", {if_rdata, d_rdata, if_done, d_done});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    model_mem[idx(a, 0)] = w[7:0];
    model_mem[idx(a, 1)] = w[15:8];
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[idx(a, i)] !== model_mem[idx(a, i)]) begin
        failures++;
        $display("FAIL midreset_mem[%0d]: got %h expected %h", i, ram[idx(a, i)], model_mem[idx(a, i)]);
      end
    end
    run_access(1'b1, 1'b0, F3_W, a, 32'h0);
    checks++;
    if (obs_done !== 6 || d_rdata !== model_read(a, F3_W)) begin
      failures++;
      $display("FAIL midreset_next_load: got done=%0d data=%h expected done=6 data=%h",
               obs_done, d_rdata, model_read(a, F3_W));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      bit          is_d;
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_val;
      int          n;
      int          exp_done;
      is_d  = ($urandom_range(0, 2) != 0);
      we    = is_d && ($urandom_range(0, 1) == 1);
      f3    = is_d ? 3'($urandom_range(0, 7)) : F3_W;
      addr  = $urandom;
      if ($urandom_range(0, 3) == 0)
        addr = (addr & 32'hFFFF_F000) | (32'hFFD + 32'($urandom_range(0, 2)));
      wdata = $urandom;
      n = model_bytes(f3);
      exp_done = (n == 0) ? 1 : (we ? n + 1 : n + 2);
      exp_val  = model_read(addr, f3);
      run_access(is_d, we, f3, addr, wdata);
      checks++;
      if (obs_done !== exp_done || obs_nram !== n || obs_stray !== 0) begin
        failures++;
        $display("FAIL rand[%0d] timing: got done=%0d n=%0d stray=%0d expected done=%0d n=%0d stray=0",
                 it, obs_done, obs_nram, obs_stray, exp_done, n);
      end
      for (int i = 0; i < n && i < 4; i++) begin
        checks++;
        if (obs_a[i] !== idx(addr, i)) begin
          failures++;
          $display("FAIL rand[%0d] addr[%0d]: got %h expected %h", it, i, obs_a[i], idx(addr, i));
        end
      end
      if (we) begin
        model_store(addr, f3, wdata);
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (ram[idx(addr, i)] !== model_mem[idx(addr, i)]) begin
            failures++;
            $display("FAIL rand[%0d] mem[%0d]: got %h expected %h",
                     it, i, ram[idx(addr, i)], model_mem[idx(addr, i)]);
          end
        end
      end else begin
        checks++;
        if ((is_d ? d_rdata : if_rdata) !== exp_val) begin
          failures++;
          $display("FAIL rand[%0d] rdata (port=%0d f3=%b a=%h): got %h expected %h",
                   it, is_d, f3, addr, is_d ? d_rdata : if_rdata, exp_val);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) preload(12'(i), 8'($urandom));
    test_reset();
    test_word_fetch();
    test_byte_loads();
    test_store_wrap();
    test_illegal();
    test_arbitration();
    test_reset_mid_store();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
